// File: rtl/inst_fetch_buffer_if.sv
// Instruction-bus read channel: the fetch buffer drives req/addr (master), memory returns ack/rdata (slave).
interface inst_fetch_buffer_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          bus_req_o;
  logic [AW-1:0] bus_addr_o;
  logic          bus_ack_i;
  logic [DW-1:0] bus_rdata_i;

  modport master (output bus_req_o, output bus_addr_o, input  bus_ack_i, input  bus_rdata_i);
  modport slave  (input  bus_req_o, input  bus_addr_o, output bus_ack_i, output bus_rdata_i);
endinterface

// File: rtl/inst_fetch_buffer.sv
// Sequential instruction prefetch buffer: fetches ahead over a req/ack bus into a {addr,inst} FIFO,
// answers core fetches combinationally on a head hit and requests a stall otherwise.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic [31:0]         addr_i,
  output logic [31:0]         inst_o,
  output logic                stall_req_o,
  inst_fetch_buffer_if.master bus
);
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_tag  [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [AW-1:0]    r_fetch_addr;
  logic [AW-1:0]    r_drain_addr;
  logic             r_bus_req;
  logic [AW-1:0]    r_bus_addr;

  logic             w_empty;
  logic             w_hit;
  logic             w_redirect;
  logic             w_push;
  logic [AW-1:0]    w_head_tag;
  logic [AW-1:0]    w_exp_addr;
  logic [AW-1:0]    w_fetch_nxt;
  logic [AW-1:0]    w_drain_nxt;
  logic [AW-1:0]    w_bus_addr_nxt;
  logic [CNT_W:0]   w_cnt_after_push;

  // Hit/redirect classification of the core's fetch against the expected next address
  assign w_empty          = (r_count == '0);
  assign w_head_tag       = r_tag[r_rd_ptr];
  assign w_exp_addr       = w_empty ? r_fetch_addr : w_head_tag;
  assign w_hit            = ce_i && !w_empty && (addr_i == w_head_tag);
  assign w_redirect       = ce_i && (addr_i != w_exp_addr);
  assign w_cnt_after_push = {1'b0, r_count} + (CNT_W+1)'(1) - (CNT_W+1)'(w_hit);

  assign inst_o         = (!rst && w_hit) ? r_data[r_rd_ptr] : '0;
  assign stall_req_o    = !rst && ce_i && !w_hit;
  assign bus.bus_req_o  = r_bus_req;
  assign bus.bus_addr_o = r_bus_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_push         = 1'b0;
    w_fetch_nxt    = r_fetch_addr;
    w_drain_nxt    = r_drain_addr;
    w_bus_addr_nxt = '0;
    if (w_redirect) w_fetch_nxt = addr_i;
    unique case (r_state)
      S_IDLE: begin
        if (w_redirect || (ce_i && (r_count < CNT_W'(DEPTH)))) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A redirect without ack leaves a request in flight that must be drained first
        if (w_redirect) begin
          if (!bus.bus_ack_i) begin
            w_drain_nxt = r_fetch_addr;
            w_state_nxt = S_DRAIN;
          end
        end else if (bus.bus_ack_i) begin
          w_push      = 1'b1;
          w_fetch_nxt = r_fetch_addr + AW'(4);
          if (!ce_i || (w_cnt_after_push >= (CNT_W+1)'(DEPTH))) w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (bus.bus_ack_i) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_DRAIN)      w_bus_addr_nxt = w_drain_nxt;
    else if (w_state_nxt == S_FETCH) w_bus_addr_nxt = w_fetch_nxt;
  end

  // FIFO bookkeeping, fetch/drain addresses and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_fetch_addr <= RESET_ADDR;
      r_drain_addr <= '0;
      r_bus_req    <= 1'b0;
      r_bus_addr   <= '0;
    end else begin
      r_fetch_addr <= w_fetch_nxt;
      r_drain_addr <= w_drain_nxt;
      r_bus_req    <= (w_state_nxt != S_IDLE);
      r_bus_addr   <= w_bus_addr_nxt;
      if (w_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_hit)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_hit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr]  <= r_fetch_addr;
      r_data[r_wr_ptr] <= bus.bus_rdata_i;
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed vector table, multi-cycle corner sequences and a random
// core/bus run checked against program order over a synthetic memory image.
module tb_inst_fetch_buffer;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned STALL_LIMIT = 40;
  localparam int unsigned NVEC        = 13;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        stall;
    logic        hit;
    logic        req;
    logic [31:0] baddr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        stall_req_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  inst_fetch_buffer_if bus ();

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i),
    .inst_o(inst_o), .stall_req_o(stall_req_o), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Memory model: ack after cur_lat cycles of req, data always the image word at bus_addr_o
  int unsigned fixed_lat = 0;
  bit          rand_lat  = 1'b0;
  int unsigned r_wait;
  int unsigned r_lat_rand;
  int unsigned r_ack_cnt;
  int unsigned cur_lat;
  logic        r_hold_valid;
  logic [31:0] r_hold_addr;

  assign cur_lat         = rand_lat ? r_lat_rand : fixed_lat;
  assign bus.bus_ack_i   = bus.bus_req_o && (r_wait >= cur_lat);
  assign bus.bus_rdata_i = mem_word(bus.bus_addr_o);

  always @(posedge clk) begin
    if (rst || !bus.bus_req_o || bus.bus_ack_i) r_wait <= 0;
    else                                        r_wait <= r_wait + 1;
    if (bus.bus_ack_i) r_lat_rand <= $urandom_range(0, 3);
    if (rst)                r_ack_cnt <= 0;
    else if (bus.bus_ack_i) r_ack_cnt <= r_ack_cnt + 1;
    r_hold_valid <= !rst && bus.bus_req_o && !bus.bus_ack_i;
    r_hold_addr  <= bus.bus_addr_o;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_hold();
    if (r_hold_valid && bus.bus_req_o) check("bus_addr_stable", bus.bus_addr_o, r_hold_addr);
  endtask

  task automatic cyc(input logic ce, input logic [31:0] a);
    @(negedge clk);
    ce_i   = ce;
    addr_i = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ce_i = 1'b0; addr_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t        tbl [NVEC];
  logic [31:0] pc;
  logic        rce;
  int unsigned delivered;
  int unsigned stalls;
  bit          found;

  initial begin
    tbl[0]  = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b0, 32'h000};
    tbl[1]  = '{1'b1, 32'h000, 1'b1, 1'b0, 1'b1, 32'h000};
    tbl[2]  = '{1'b1, 32'h000, 1'b0, 1'b1, 1'b1, 32'h004};
    tbl[3]  = '{1'b1, 32'h004, 1'b0, 1'b1, 1'b1, 32'h008};
    tbl[4]  = '{1'b1, 32'h008, 1'b0, 1'b1, 1'b1, 32'h00C};
    tbl[5]  = '{1'b0, 32'h00C, 1'b0, 1'b0, 1'b1, 32'h010};
    tbl[6]  = '{1'b1, 32'h00C, 1'b0, 1'b1, 1'b0, 32'h000};
    tbl[7]  = '{1'b1, 32'h010, 1'b0, 1'b1, 1'b1, 32'h014};
    tbl[8]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h018};
    tbl[9]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100};
    tbl[10] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h104};
    tbl[11] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h108};
    tbl[12] = '{1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 32'h10C};

    // Reset: outputs quiet even with the core requesting
    rst = 1'b1; ce_i = 1'b0; addr_i = '0;
    @(negedge clk); ce_i = 1'b1; addr_i = 32'h40; #1;
    check("rst_stall", stall_req_o, 0);
    check("rst_inst", inst_o, 0);
    @(negedge clk); #1;
    check("rst_bus_req", bus.bus_req_o, 0);
    check("rst_stall2", stall_req_o, 0);
    @(negedge clk); rst = 1'b0; ce_i = 1'b0;

    // Zero-wait bus: warm-up, streaming, ce gap and a redirect
    for (int i = 0; i < int'(NVEC); i++) begin
      cyc(tbl[i].ce, tbl[i].addr);
      check($sformatf("v%0d_stall", i), stall_req_o, tbl[i].stall);
      check($sformatf("v%0d_inst", i), inst_o, tbl[i].hit ? mem_word(tbl[i].addr) : 32'h0);
      check($sformatf("v%0d_req", i), bus.bus_req_o, tbl[i].req);
      if (tbl[i].req) check($sformatf("v%0d_baddr", i), bus.bus_addr_o, tbl[i].baddr);
    end

    // Latency-3 sequential stream of 32 words
    fixed_lat = 3; do_reset();
    pc = '0; delivered = 0; stalls = 0;
    for (int c = 0; c < 400 && delivered < 32; c++) begin
      cyc(1'b1, pc); check_hold();
      if (!stall_req_o) begin
        check("seq_inst", inst_o, mem_word(pc));
        pc += 32'd4; delivered++;
      end else stalls++;
    end
    check("seq_count", delivered, 32);
    check("seq_stalled", stalls > 0, 1);

    // Redirect 0x10 -> 0x100 while 0x14 is in flight
    do_reset(); pc = '0;
    for (int c = 0; c < 200 && pc != 32'h14; c++) begin
      cyc(1'b1, pc);
      if (!stall_req_o) begin check("redir_pre_inst", inst_o, mem_word(pc)); pc += 32'd4; end
    end
    check("redir_reach", pc, 32'h14);
    cyc(1'b1, 32'h100);
    check("redir_stall", stall_req_o, 1);
    check("redir_outstanding", {bus.bus_req_o, bus.bus_addr_o}, {1'b1, 32'h14});
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc(1'b1, 32'h100);
      check("drain_addr", {bus.bus_req_o, bus.bus_addr_o}, {1'b1, 32'h14});
      check("drain_stall", stall_req_o, 1);
      found = bus.bus_ack_i;
    end
    check("drain_acked", found, 1);
    cyc(1'b1, 32'h100);
    check("redir_new_req", {bus.bus_req_o, bus.bus_addr_o}, {1'b1, 32'h100});
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (!stall_req_o) begin found = 1'b1; check("redir_inst", inst_o, mem_word(32'h100)); end
      else cyc(1'b1, 32'h100);
    end
    check("redir_delivered", found, 1);

    // Core disables fetch: requests stop, fetched-ahead words survive
    fixed_lat = 0; do_reset(); pc = '0; delivered = 0;
    for (int c = 0; c < 50 && pc != 32'h10; c++) begin
      cyc(1'b1, pc);
      if (!stall_req_o) begin check("hold_pre_inst", inst_o, mem_word(pc)); pc += 32'd4; delivered++; end
    end
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, pc);
      check("ce0_quiet", {stall_req_o, inst_o}, 33'h0);
      if (c >= 1) check("ce0_no_req", bus.bus_req_o, 0);
    end
    check("ahead_bound", (r_ack_cnt - delivered) <= DEPTH, 1);
    cyc(1'b1, pc);
    check("resume_no_stall", stall_req_o, 0);
    for (int c = 0; c < 40 && pc != 32'h30; c++) begin
      if (c > 0) cyc(1'b1, pc);
      if (!stall_req_o) begin check("resume_inst", inst_o, mem_word(pc)); pc += 32'd4; end
    end
    check("resume_reach", pc, 32'h30);

    // Reset while the request for 0x40 is outstanding
    fixed_lat = 3; do_reset(); pc = '0; found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      cyc(1'b1, pc);
      if (!stall_req_o) begin check("rst6_pre_inst", inst_o, mem_word(pc)); pc += 32'd4; end
      if (bus.bus_req_o && bus.bus_addr_o == 32'h40) found = 1'b1;
    end
    check("rst6_found", found, 1);
    @(negedge clk); rst = 1'b1; ce_i = 1'b1; addr_i = pc; #1;
    check("rst6_quiet", {stall_req_o, inst_o}, 33'h0);
    check("rst6_outstanding", {bus.bus_req_o, bus.bus_addr_o}, {1'b1, 32'h40});
    @(negedge clk); rst = 1'b0; ce_i = 1'b1; addr_i = 32'h0; #1;
    check("rst6_req_drop", bus.bus_req_o, 0);
    check("rst6_miss", stall_req_o, 1);
    cyc(1'b1, 32'h0);
    check("rst6_restart", {bus.bus_req_o, bus.bus_addr_o}, {1'b1, 32'h0});
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc(1'b1, 32'h0);
      if (!stall_req_o) begin found = 1'b1; check("rst6_inst", inst_o, mem_word(32'h0)); end
    end
    check("rst6_delivered", found, 1);

    // Random core (enables, jumps, wrap) against random bus latency
    rand_lat = 1'b1; do_reset(); pc = '0; stalls = 0;
    for (int c = 0; c < 3000; c++) begin
      rce = ($urandom_range(0, 7) != 0);
      cyc(rce, pc); check_hold();
      if (!rce) check("rnd_ce0", {stall_req_o, inst_o}, 33'h0);
      else if (!stall_req_o) begin
        check("rnd_inst", inst_o, mem_word(pc));
        stalls = 0;
        case ($urandom_range(0, 15))
          0, 1:    pc = 32'($urandom_range(0, 255) * 4);
          2:       pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
          default: pc += 32'd4;
        endcase
      end else begin
        stalls++;
        check("rnd_stall_bound", stalls <= STALL_LIMIT, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
